// File: rtl/trafficlight_pkg.sv
// Shared lamp codes, phase encoding and lamp enum for the traffic-light monitor.
package trafficlight_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        MON_IDLE = 3'd0,
        NS_GO    = 3'd1,
        NS_WARN  = 3'd2,
        EW_GO    = 3'd3,
        EW_WARN  = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        BAD    = 2'd3
    } lamp_t;

    // Legal successor in the NS_GO -> NS_WARN -> EW_GO -> EW_WARN ring.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GO:   return NS_WARN;
            NS_WARN: return EW_GO;
            EW_GO:   return EW_WARN;
            EW_WARN: return NS_GO;
            default: return MON_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/trafficlight_monitor_light_decode.sv
// Combinational decode of one 3-bit lamp code into a lamp colour.
module light_decode
    import trafficlight_pkg::*;
(
    input  logic [2:0] i_code,
    output lamp_t      o_lamp
);

    always_comb begin
        o_lamp = BAD;
        case (i_code)
            LIGHT_RED:    o_lamp = RED;
            LIGHT_YELLOW: o_lamp = YELLOW;
            LIGHT_GREEN:  o_lamp = GREEN;
            default:      o_lamp = BAD;
        endcase
    end

endmodule

// File: rtl/trafficlight_monitor.sv
// Passive lamp-output checker: tracks phase order and dwell times, raises sticky error flags.
module trafficlight_monitor
    import trafficlight_pkg::*;
#(
    parameter int GREEN_MIN  = 5,
    parameter int YELLOW_LEN = 2,
    parameter int STUCK_MAX  = 50,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  nslight,
    input  logic [2:0]  ewlight,
    input  logic        err_clr,
    output logic [2:0]  phase,
    output logic        synced,
    output logic        err_conflict,
    output logic        err_illegal,
    output logic        err_sequence,
    output logic        err_timing,
    output logic        err_stuck,
    output logic        err_any,
    output logic [15:0] cycle_count
);

    localparam logic [CNT_W-1:0] C_GREEN_MIN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] C_YELLOW    = CNT_W'(YELLOW_LEN);
    localparam logic [CNT_W-1:0] C_STUCK_HIT = CNT_W'(STUCK_MAX + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]       r_ns_p0, r_ew_p0;
    lamp_t            w_ns_lamp, w_ew_lamp;
    phase_t           r_phase, w_phase_nxt, w_obs;
    logic             r_synced, w_synced_nxt;
    logic             r_first, w_first_nxt;
    logic [CNT_W-1:0] r_dwell, w_dwell_nxt;
    logic [15:0]      r_cycles, w_cycles_nxt;
    logic             r_err_conflict, r_err_illegal, r_err_sequence, r_err_timing, r_err_stuck;
    logic             w_conflict, w_illegal, w_legal;
    logic             w_seq_det, w_tim_det, w_stuck_det;

    // ---- stage p0: lamp samples registered ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ns_p0 <= LIGHT_RED;
            r_ew_p0 <= LIGHT_RED;
        end else begin
            r_ns_p0 <= nslight;
            r_ew_p0 <= ewlight;
        end
    end

    light_decode u_dec_ns (.i_code(r_ns_p0), .o_lamp(w_ns_lamp));
    light_decode u_dec_ew (.i_code(r_ew_p0), .o_lamp(w_ew_lamp));

    // Only properly decoded yellow/green counts as "go"; garbage codes are reported as illegal instead.
    assign w_conflict = (w_ns_lamp == YELLOW || w_ns_lamp == GREEN) &&
                        (w_ew_lamp == YELLOW || w_ew_lamp == GREEN);
    assign w_illegal  = !w_conflict && (w_ns_lamp == BAD || w_ew_lamp == BAD);
    assign w_legal    = !w_conflict && !w_illegal;

    always_comb begin
        w_obs = MON_IDLE;
        if (w_ns_lamp == GREEN  && w_ew_lamp == RED)    w_obs = NS_GO;
        if (w_ns_lamp == YELLOW && w_ew_lamp == RED)    w_obs = NS_WARN;
        if (w_ns_lamp == RED    && w_ew_lamp == GREEN)  w_obs = EW_GO;
        if (w_ns_lamp == RED    && w_ew_lamp == YELLOW) w_obs = EW_WARN;
    end

    always_comb begin
        w_phase_nxt  = r_phase;
        w_synced_nxt = r_synced;
        w_first_nxt  = r_first;
        w_dwell_nxt  = r_dwell;
        w_cycles_nxt = r_cycles;
        w_seq_det    = 1'b0;
        w_tim_det    = 1'b0;
        if (r_phase == MON_IDLE) begin
            if (w_legal && w_obs != MON_IDLE) begin
                w_phase_nxt  = w_obs;
                w_synced_nxt = 1'b1;
                w_first_nxt  = 1'b1;
                w_dwell_nxt  = CNT_W'(1);
            end
        end else if (!w_legal || w_obs == r_phase) begin
            w_dwell_nxt = sat_inc(r_dwell);
        end else if (w_obs == next_phase(r_phase)) begin
            // The phase seen first after sync was entered mid-way, so its length is meaningless.
            if (!r_first) begin
                if (r_phase == NS_GO || r_phase == EW_GO)
                    w_tim_det = (r_dwell < C_GREEN_MIN);
                else
                    w_tim_det = (r_dwell != C_YELLOW);
            end
            if (r_phase == EW_WARN)
                w_cycles_nxt = r_cycles + 16'd1;
            w_phase_nxt = w_obs;
            w_first_nxt = 1'b0;
            w_dwell_nxt = CNT_W'(1);
        end else begin
            w_seq_det    = 1'b1;
            w_phase_nxt  = w_obs;
            w_first_nxt  = 1'b0;
            w_synced_nxt = (w_obs != MON_IDLE);
            w_dwell_nxt  = (w_obs != MON_IDLE) ? CNT_W'(1) : '0;
        end
    end

    assign w_stuck_det = (w_dwell_nxt == C_STUCK_HIT) && (r_dwell != C_STUCK_HIT);

    // ---- stage p1: phase tracking and sticky flags; a fresh detection beats err_clr ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase        <= MON_IDLE;
            r_synced       <= 1'b0;
            r_first        <= 1'b0;
            r_dwell        <= '0;
            r_cycles       <= '0;
            r_err_conflict <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_err_sequence <= 1'b0;
            r_err_timing   <= 1'b0;
            r_err_stuck    <= 1'b0;
        end else begin
            r_phase        <= w_phase_nxt;
            r_synced       <= w_synced_nxt;
            r_first        <= w_first_nxt;
            r_dwell        <= w_dwell_nxt;
            r_cycles       <= w_cycles_nxt;
            r_err_conflict <= (r_err_conflict & ~err_clr) | w_conflict;
            r_err_illegal  <= (r_err_illegal  & ~err_clr) | w_illegal;
            r_err_sequence <= (r_err_sequence & ~err_clr) | w_seq_det;
            r_err_timing   <= (r_err_timing   & ~err_clr) | w_tim_det;
            r_err_stuck    <= (r_err_stuck    & ~err_clr) | w_stuck_det;
        end
    end

    assign phase        = r_phase;
    assign synced       = r_synced;
    assign err_conflict = r_err_conflict;
    assign err_illegal  = r_err_illegal;
    assign err_sequence = r_err_sequence;
    assign err_timing   = r_err_timing;
    assign err_stuck    = r_err_stuck;
    assign err_any      = r_err_conflict | r_err_illegal | r_err_sequence | r_err_timing | r_err_stuck;
    assign cycle_count  = r_cycles;

endmodule
